alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle sequencer that computes the low WIDTH bits of an integer product (RV32M MUL semantics) by driving the shared combinational ALU with repeated ADD operations (shift-and-add). It sits beside the execute stage. While a multiply runs it claims the ALU through `alu_own`, and the top level muxes the ALU operand and control inputs accordingly. Requests and responses use valid/ready handshakes.

## Interface
- `WIDTH`, 32, operand/result width
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-high reset
- `req_valid` in 1: request offered
- `req_ready` out 1: sequencer can accept (high only in IDLE)
- `op_a` in WIDTH: multiplicand
- `op_b` in WIDTH: multiplier
- `cancel` in 1: abort in-flight operation, no response
- `resp_valid` out 1: result available
- `resp_ready` in 1: consumer takes result
- `resp_data` out WIDTH: low WIDTH bits of op_a*op_b
- `alu_own` out 1: sequencer owns the ALU this cycle
- `alu_a` out WIDTH: ALU operand a
- `alu_b` out WIDTH: ALU operand b
- `alu_ctrl` out 3: ALU op (ADD = 3'b000)
- `alu_out` in WIDTH: combinational ALU result, same cycle

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - `acc`: accumulator, WIDTH
  - `mcand`: shifted multiplicand, WIDTH
  - `mplier`: shifted multiplier, WIDTH
  - `cnt`: iteration count, clog2(WIDTH) bits
- IDLE, on `req_valid && req_ready`:
  - Load `acc` = 0, `mcand` = `op_a`, `mplier` = `op_b`, `cnt` = 0.
  - If `op_b` == 0, go to DONE; otherwise go to RUN.
- RUN, each cycle:
  - Drive `alu_own` = 1, `alu_a` = `acc`, `alu_b` = `mcand`, `alu_ctrl` = 3'b000.
  - If `mplier[0]`, `acc` <= `alu_out`; otherwise `acc` holds.
  - `mcand` <= `mcand` << 1, `mplier` <= `mplier` >> 1, `cnt` <= `cnt` + 1.
- RUN exit: go to DONE when `(mplier >> 1) == 0` or `cnt == WIDTH-1` (early termination).
- DONE:
  - `resp_valid` = 1 and `resp_data` = `acc`, both held stable until `resp_ready`.
  - On `resp_valid && resp_ready`, go to IDLE.
- Arithmetic is modulo 2^WIDTH. Carries out of bit WIDTH-1 are discarded, so signed and unsigned operands give the same low word.
- Outside RUN: `alu_own` = 0, `alu_a` = `alu_b` = 0, `alu_ctrl` = 3'b000.
- `cancel`:
  - Sampled in RUN or DONE; forces IDLE on the next edge, clears `acc`, and no response is produced.
  - Ignored in IDLE. It does not block a same-cycle request accept.
- The ALU `zero` output is not used.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_data` = 0, `alu_own` = 0, `alu_a` = `alu_b` = 0, `alu_ctrl` = 3'b000, all internal registers 0.
- Reset mid-operation drops the operation immediately. No response is produced.
- `req_ready` is combinational from state (IDLE only). Back-to-back accepts are impossible: minimum spacing is accept, then at least one DONE cycle, then IDLE.
- Latency from accept edge to `resp_valid` high is N+1 edges, where N = index of the highest set bit of `op_b` + 1 (1..WIDTH). When `op_b` == 0, `resp_valid` is high one cycle after accept.
- Worst case is `op_b[WIDTH-1]` set: WIDTH RUN cycles.
- `alu_own` is high for exactly the RUN cycles. The `alu_out` path is combinational into the `acc` D-input, so it is timing-critical with the ALU adder.
- `cancel` and `resp_ready` asserted together in DONE: the result counts as consumed, and the next state is IDLE either way.

## Structure
- A shared package holds:
  - The ALU op encodings (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SRL 110, SRA 111); this block uses ADD only.
  - The sequencer state encoding.
- A single module. The ALU is instantiated outside, and the top level muxes `alu_a`, `alu_b` and `alu_ctrl` on `alu_own`.

## Test plan
- `op_a` = 6, `op_b` = 7 -> `alu_own` high for 3 cycles, `resp_data` = 42, `resp_valid` 4 edges after accept.
- `op_a` = 0xFFFFFFFF, `op_b` = 0xFFFFFFFF -> 32 RUN cycles, `resp_data` = 0x00000001.
- `op_b` = 0, `op_a` = 0x1234 -> no RUN cycles, `resp_data` = 0, `resp_valid` 1 cycle after accept, `alu_own` never high.
- `op_a` = 0x80000000, `op_b` = 2 -> `resp_data` = 0 (wrap); hold `resp_ready` low 5 cycles -> `resp_valid`/`resp_data` stable and `req_ready` = 0 throughout.
- `cancel` at RUN cycle 3 of 0x10 * 0x55 -> IDLE next cycle, no `resp_valid`. A following request 3*5 returns 15.
- Assert `reset` mid-RUN -> all outputs at reset values asynchronously. After release, 9*9 returns 81.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// Shared encodings for the shift-and-add multiply sequencer.
// Holds the ALU op codes (only ADD is used by the sequencer) and the
// sequencer state encoding.
package alu_mul_seq_pkg;

  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response handshake plus the shared-ALU borrowing signals of the
// multiply sequencer.
//   slave  : the sequencer (accepts requests, drives ALU operands)
//   master : the execute-stage side (issues requests, owns the ALU mux)
interface alu_mul_seq_if #(
  parameter int unsigned WIDTH = 32
);
  import alu_mul_seq_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic                cancel;
  logic                resp_valid;
  logic                resp_ready;
  logic [WIDTH-1:0]    resp_data;
  logic                alu_own;
  logic [WIDTH-1:0]    alu_a;
  logic [WIDTH-1:0]    alu_b;
  logic [ALU_OP_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]    alu_out;

  modport slave (
    input  req_valid, op_a, op_b, cancel, resp_ready, alu_out,
    output req_ready, resp_valid, resp_data, alu_own, alu_a, alu_b, alu_ctrl
  );

  modport master (
    output req_valid, op_a, op_b, cancel, resp_ready, alu_out,
    input  req_ready, resp_valid, resp_data, alu_own, alu_a, alu_b, alu_ctrl
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle multiplier: low WIDTH bits of op_a*op_b computed by borrowing
// the shared combinational ALU for one ADD per multiplier bit.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : alu_mul_seq_if.slave (request/response handshake, ALU borrow)
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_mul_seq_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  seq_state_e       state, state_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [WIDTH-1:0] mcand, mcand_d;
  logic [WIDTH-1:0] mplier, mplier_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             run;

  assign run = (state == S_RUN);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      mcand  <= mcand_d;
      mplier <= mplier_d;
      cnt    <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    mcand_d  = mcand;
    mplier_d = mplier;
    cnt_d    = cnt;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          acc_d    = '0;
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          cnt_d    = '0;
          state_d  = (bus.op_b == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.cancel) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end else begin
          // alu_out = acc + mcand this cycle; keep it only for a set multiplier bit
          if (mplier[0]) acc_d = bus.alu_out;
          mcand_d  = mcand << 1;
          mplier_d = mplier >> 1;
          cnt_d    = cnt + CNT_W'(1);
          // Stop once no set multiplier bits remain
          if (((mplier >> 1) == '0) || (cnt == CNT_W'(WIDTH - 1))) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.cancel) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end else if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and ALU-borrow outputs decode directly from registered state
  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_DONE);
  assign bus.resp_data  = acc;
  assign bus.alu_own    = run;
  assign bus.alu_a      = run ? acc : '0;
  assign bus.alu_b      = run ? mcand : '0;
  assign bus.alu_ctrl   = ALU_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed testbench for alu_mul_seq with a behavioural ADD-capable ALU.
module tb_alu_mul_seq;

  localparam int unsigned WIDTH = 32;
  localparam int          LIMIT = 200;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  alu_mul_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_mul_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Shared ALU stand-in: only ADD matters for this block
  assign bus.alu_out = (bus.alu_ctrl == 3'b000) ? (bus.alu_a + bus.alu_b) : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one multiply and collect result, edge latency and RUN-cycle count
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] data, output int lat, output int own,
                        output int bad_ctrl, output bit to);
    bus.op_a      = a;
    bus.op_b      = b;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; own = 0; bad_ctrl = 0; to = 1'b0;
    while (bus.resp_valid !== 1'b1) begin
      if (lat >= LIMIT) begin
        to = 1'b1;
        break;
      end
      if (bus.alu_own === 1'b1) begin
        own++;
        if (bus.alu_ctrl !== 3'b000) bad_ctrl++;
      end
      @(posedge clk); #1;
      lat++;
    end
    data = bus.resp_data;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_total += 7;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b want 1", bus.req_ready); else n_pass++;
    if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %0b want 0", bus.resp_valid); else n_pass++;
    if (bus.resp_data !== 32'h0) $display("FAIL reset_resp_data: got %0h want 0", bus.resp_data); else n_pass++;
    if (bus.alu_own !== 1'b0) $display("FAIL reset_alu_own: got %0b want 0", bus.alu_own); else n_pass++;
    if (bus.alu_a !== 32'h0) $display("FAIL reset_alu_a: got %0h want 0", bus.alu_a); else n_pass++;
    if (bus.alu_b !== 32'h0) $display("FAIL reset_alu_b: got %0h want 0", bus.alu_b); else n_pass++;
    if (bus.alu_ctrl !== 3'b000) $display("FAIL reset_alu_ctrl: got %0b want 000", bus.alu_ctrl); else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] d; int lat, own, bad; bit to;
    do_mul(32'd6, 32'd7, d, lat, own, bad, to);
    n_total += 5;
    if (to) $display("FAIL basic_timeout: got timeout want response"); else n_pass++;
    if (d !== 32'd42) $display("FAIL basic_data: got %0d want 42", d); else n_pass++;
    if (lat != 4) $display("FAIL basic_latency: got %0d want 4", lat); else n_pass++;
    if (own != 3) $display("FAIL basic_own_cycles: got %0d want 3", own); else n_pass++;
    if (bad != 0) $display("FAIL basic_alu_ctrl: got %0d non-ADD cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_max();
    logic [31:0] d; int lat, own, bad; bit to;
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, d, lat, own, bad, to);
    n_total += 4;
    if (to) $display("FAIL max_timeout: got timeout want response"); else n_pass++;
    if (d !== 32'h0000_0001) $display("FAIL max_data: got %0h want 1", d); else n_pass++;
    if (lat != 33) $display("FAIL max_latency: got %0d want 33", lat); else n_pass++;
    if (own != 32) $display("FAIL max_own_cycles: got %0d want 32", own); else n_pass++;
  endtask

  task automatic test_zero_mplier();
    logic [31:0] d; int lat, own, bad; bit to;
    do_mul(32'h1234, 32'h0, d, lat, own, bad, to);
    n_total += 4;
    if (to) $display("FAIL zero_timeout: got timeout want response"); else n_pass++;
    if (d !== 32'h0) $display("FAIL zero_data: got %0h want 0", d); else n_pass++;
    if (lat != 1) $display("FAIL zero_latency: got %0d want 1", lat); else n_pass++;
    if (own != 0) $display("FAIL zero_own_cycles: got %0d want 0", own); else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat; int bad;
    bus.op_a = 32'h8000_0000; bus.op_b = 32'd2; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    n_total += 2;
    if (lat != 3) $display("FAIL bp_latency: got %0d want 3", lat); else n_pass++;
    if (bus.resp_data !== 32'h0) $display("FAIL bp_wrap_data: got %0h want 0", bus.resp_data); else n_pass++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_total += 3;
      if (bus.resp_valid !== 1'b1) $display("FAIL bp_hold_valid: cycle %0d got %0b want 1", i, bus.resp_valid); else n_pass++;
      if (bus.resp_data !== 32'h0) $display("FAIL bp_hold_data: cycle %0d got %0h want 0", i, bus.resp_data); else n_pass++;
      if (bus.req_ready !== 1'b0) $display("FAIL bp_hold_req_ready: cycle %0d got %0b want 0", i, bus.req_ready); else n_pass++;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    n_total += 2;
    if (bus.req_ready !== 1'b1) $display("FAIL bp_release_req_ready: got %0b want 1", bus.req_ready); else n_pass++;
    if (bus.resp_valid !== 1'b0) $display("FAIL bp_release_valid: got %0b want 0", bus.resp_valid); else n_pass++;
  endtask

  task automatic test_cancel();
    logic [31:0] d; int lat, own, bad, seen; bit to;
    bus.op_a = 32'h10; bus.op_b = 32'h55; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    // RUN cycles 1 and 2, then raise cancel during cycle 3
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if (bus.alu_own !== 1'b1) $display("FAIL cancel_run_own: cycle %0d got %0b want 1", i + 1, bus.alu_own); else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (bus.alu_own !== 1'b1) $display("FAIL cancel_run_own: cycle 3 got %0b want 1", bus.alu_own); else n_pass++;
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    n_total += 4;
    if (bus.req_ready !== 1'b1) $display("FAIL cancel_req_ready: got %0b want 1", bus.req_ready); else n_pass++;
    if (bus.resp_valid !== 1'b0) $display("FAIL cancel_resp_valid: got %0b want 0", bus.resp_valid); else n_pass++;
    if (bus.alu_own !== 1'b0) $display("FAIL cancel_alu_own: got %0b want 0", bus.alu_own); else n_pass++;
    if (bus.resp_data !== 32'h0) $display("FAIL cancel_acc_clear: got %0h want 0", bus.resp_data); else n_pass++;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid === 1'b1) seen++;
    end
    n_total++;
    if (seen != 0) $display("FAIL cancel_no_resp: got %0d valid cycles want 0", seen); else n_pass++;
    do_mul(32'd3, 32'd5, d, lat, own, bad, to);
    n_total += 3;
    if (to) $display("FAIL cancel_next_timeout: got timeout want response"); else n_pass++;
    if (d !== 32'd15) $display("FAIL cancel_next_data: got %0d want 15", d); else n_pass++;
    if (lat != 4) $display("FAIL cancel_next_latency: got %0d want 4", lat); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d; int lat, own, bad; bit to;
    bus.op_a = 32'h1234_5678; bus.op_b = 32'hFFFF; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    n_total++;
    if (bus.alu_own !== 1'b1) $display("FAIL rst_mid_pre_own: got %0b want 1", bus.alu_own); else n_pass++;
    reset = 1'b1;
    #1;
    n_total += 6;
    if (bus.req_ready !== 1'b1) $display("FAIL rst_mid_req_ready: got %0b want 1", bus.req_ready); else n_pass++;
    if (bus.resp_valid !== 1'b0) $display("FAIL rst_mid_resp_valid: got %0b want 0", bus.resp_valid); else n_pass++;
    if (bus.resp_data !== 32'h0) $display("FAIL rst_mid_resp_data: got %0h want 0", bus.resp_data); else n_pass++;
    if (bus.alu_own !== 1'b0) $display("FAIL rst_mid_alu_own: got %0b want 0", bus.alu_own); else n_pass++;
    if (bus.alu_a !== 32'h0) $display("FAIL rst_mid_alu_a: got %0h want 0", bus.alu_a); else n_pass++;
    if (bus.alu_b !== 32'h0) $display("FAIL rst_mid_alu_b: got %0h want 0", bus.alu_b); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    do_mul(32'd9, 32'd9, d, lat, own, bad, to);
    n_total += 4;
    if (to) $display("FAIL rst_next_timeout: got timeout want response"); else n_pass++;
    if (d !== 32'd81) $display("FAIL rst_next_data: got %0d want 81", d); else n_pass++;
    if (lat != 5) $display("FAIL rst_next_latency: got %0d want 5", lat); else n_pass++;
    if (own != 4) $display("FAIL rst_next_own_cycles: got %0d want 4", own); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.cancel = 1'b0;
    bus.resp_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_max();
    test_zero_mplier();
    test_backpressure();
    test_cancel();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
